// File: rtl/ahb_rr_arbiter_if.sv
// Arbiter-side bundle of the shared AHB port: requests, muxed owner control and handover.
// master: request/control side (masters plus slave Hready); slave: the arbiter itself.
interface ahb_rr_arbiter_if #(
   parameter int NUM_MST = 2,
   parameter int MST_W   = 1
);
   logic [NUM_MST-1:0] Hbusreq;
   logic [NUM_MST-1:0] Hlock;
   logic [1:0]         Htrans;
   logic [2:0]         Hburst;
   logic               Hready;
   logic [NUM_MST-1:0] Hgrant;
   logic [MST_W-1:0]   Hmaster;
   logic [MST_W-1:0]   Hmaster_d;
   logic               Hmastlock;

   modport master (
      output Hbusreq, Hlock, Htrans, Hburst, Hready,
      input  Hgrant, Hmaster, Hmaster_d, Hmastlock
   );

   modport slave (
      input  Hbusreq, Hlock, Htrans, Hburst, Hready,
      output Hgrant, Hmaster, Hmaster_d, Hmastlock
   );
endinterface

// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB arbiter: registered one-hot Hgrant, owner pipeline Hmaster/Hmaster_d.
// Ports: Hclk, Hresetn (async, low), bus (slave modport: Hbusreq/Hlock/Htrans/Hburst/Hready in).
module ahb_rr_arbiter #(
   parameter int NUM_MST     = 2,
   parameter int DEFAULT_MST = 0,
   parameter int MST_W       = 1
) (
   input logic             Hclk,
   input logic             Hresetn,
   ahb_rr_arbiter_if.slave bus
);

   localparam logic [1:0] TR_IDLE   = 2'd0;
   localparam logic [1:0] TR_BUSY   = 2'd1;
   localparam logic [1:0] TR_NONSEQ = 2'd2;
   localparam logic [1:0] TR_SEQ    = 2'd3;

   localparam logic [MST_W-1:0]   DEF    = MST_W'(DEFAULT_MST);
   localparam logic [NUM_MST-1:0] DEF_OH = NUM_MST'(1) << DEFAULT_MST;
   localparam logic [MST_W:0]     NUM_W  = (MST_W+1)'(NUM_MST);

   logic [NUM_MST-1:0] grant_q;
   logic [NUM_MST-1:0] grant_nxt;
   logic [MST_W-1:0]   mst_q;
   logic [MST_W-1:0]   mst_d_q;
   logic [MST_W-1:0]   rr_q;
   logic [MST_W-1:0]   gidx;
   logic [MST_W-1:0]   winner;
   logic [MST_W:0]     cand;
   logic               found;
   logic               lock_q;
   logic               freeze;
   logic [3:0]         cnt_q;
   logic [3:0]         cnt_nxt;

   always_comb begin
      gidx = '0;
      for (int i = 0; i < NUM_MST; i++) begin
         if (grant_q[i]) gidx = MST_W'(i);
      end
   end

   // Remaining fixed-burst beats after this edge's transfer.
   always_comb begin
      cnt_nxt = cnt_q;
      case (bus.Htrans)
         TR_NONSEQ: begin
            case (bus.Hburst[2:1])
               2'd1:    cnt_nxt = 4'd3;
               2'd2:    cnt_nxt = 4'd7;
               2'd3:    cnt_nxt = 4'd15;
               default: cnt_nxt = 4'd0;
            endcase
         end
         TR_SEQ:  cnt_nxt = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
         TR_BUSY: cnt_nxt = cnt_q;
         TR_IDLE: cnt_nxt = 4'd0;
         default: cnt_nxt = 4'd0;
      endcase
   end

   // Post-edge count is used, so a burst starting on this edge freezes it.
   assign freeze = (cnt_nxt >= 4'd2) || bus.Hlock[gidx];

   // Search upward from the slot after the last winner, wrapping.
   always_comb begin
      winner = DEF;
      found  = 1'b0;
      cand   = '0;
      for (int i = 1; i <= NUM_MST; i++) begin
         cand = (MST_W+1)'(rr_q) + (MST_W+1)'(i);
         if (cand >= NUM_W) cand = cand - NUM_W;
         if (!found && bus.Hbusreq[cand[MST_W-1:0]]) begin
            found  = 1'b1;
            winner = cand[MST_W-1:0];
         end
      end
      grant_nxt         = '0;
      grant_nxt[winner] = 1'b1;
   end

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         grant_q <= DEF_OH;
         mst_q   <= DEF;
         mst_d_q <= DEF;
         lock_q  <= 1'b0;
         cnt_q   <= 4'd0;
         rr_q    <= DEF;
      end else if (bus.Hready) begin
         mst_q   <= gidx;
         mst_d_q <= mst_q;
         lock_q  <= bus.Hlock[gidx];
         cnt_q   <= cnt_nxt;
         if (!freeze) begin
            grant_q <= grant_nxt;
            // Parking leaves the pointer where the last real winner left it.
            if (found) rr_q <= winner;
         end
      end
   end

   assign bus.Hgrant    = grant_q;
   assign bus.Hmaster   = mst_q;
   assign bus.Hmaster_d = mst_d_q;
   assign bus.Hmastlock = lock_q;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed bench for ahb_rr_arbiter with two masters.
// One task per scenario; expected values hand-computed.
module tb_ahb_rr_arbiter;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BUSY   = 2'd1;
   localparam logic [1:0] NONSEQ = 2'd2;
   localparam logic [1:0] SEQ    = 2'd3;

   logic Hclk;
   logic Hresetn;
   int   n_tests;
   int   n_fail;

   ahb_rr_arbiter_if #(.NUM_MST(2), .MST_W(1)) bus ();

   ahb_rr_arbiter #(
      .NUM_MST(2),
      .DEFAULT_MST(0),
      .MST_W(1)
   ) dut (
      .Hclk(Hclk),
      .Hresetn(Hresetn),
      .bus(bus)
   );

   initial Hclk = 1'b0;
   always #5 Hclk = ~Hclk;

   task automatic step();
      @(posedge Hclk);
      #1;
   endtask

   task automatic do_reset();
      Hresetn     = 1'b0;
      bus.Hbusreq = 2'b00;
      bus.Hlock   = 2'b00;
      bus.Htrans  = IDLE;
      bus.Hburst  = 3'd0;
      bus.Hready  = 1'b1;
      #12;
      @(negedge Hclk);
      Hresetn = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      if (bus.Hgrant !== 2'b01) begin n_fail++; $display("FAIL t1_rst_grant got=%b exp=01", bus.Hgrant); end n_tests++;
      if (bus.Hmaster !== 1'b0) begin n_fail++; $display("FAIL t1_rst_hmaster got=%b exp=0", bus.Hmaster); end n_tests++;
      if (bus.Hmaster_d !== 1'b0) begin n_fail++; $display("FAIL t1_rst_hmaster_d got=%b exp=0", bus.Hmaster_d); end n_tests++;
      if (bus.Hmastlock !== 1'b0) begin n_fail++; $display("FAIL t1_rst_lock got=%b exp=0", bus.Hmastlock); end n_tests++;
      step();
      if (bus.Hgrant !== 2'b01) begin n_fail++; $display("FAIL t1_park got=%b exp=01", bus.Hgrant); end n_tests++;
      bus.Hbusreq = 2'b10;
      step();
      if (bus.Hgrant !== 2'b10) begin n_fail++; $display("FAIL t1_m1_grant got=%b exp=10", bus.Hgrant); end n_tests++;
      if (bus.Hmaster !== 1'b0) begin n_fail++; $display("FAIL t1_m1_hm_early got=%b exp=0", bus.Hmaster); end n_tests++;
      step();
      if (bus.Hmaster !== 1'b1) begin n_fail++; $display("FAIL t1_m1_hm got=%b exp=1", bus.Hmaster); end n_tests++;
      if (bus.Hmaster_d !== 1'b0) begin n_fail++; $display("FAIL t1_m1_hmd_early got=%b exp=0", bus.Hmaster_d); end n_tests++;
      step();
      if (bus.Hmaster_d !== 1'b1) begin n_fail++; $display("FAIL t1_m1_hmd got=%b exp=1", bus.Hmaster_d); end n_tests++;
   endtask

   task automatic test_alternate();
      logic e, ep, ep2;
      logic [1:0] eg;
      do_reset();
      bus.Hbusreq = 2'b11;
      bus.Htrans  = NONSEQ;
      bus.Hburst  = 3'd0;
      ep  = 1'b0;
      ep2 = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         step();
         e  = (k % 2) == 1;
         eg = e ? 2'b10 : 2'b01;
         if (bus.Hgrant !== eg) begin n_fail++; $display("FAIL t2_grant[%0d] got=%b exp=%b", k, bus.Hgrant, eg); end n_tests++;
         if (bus.Hmaster !== ep) begin n_fail++; $display("FAIL t2_hm[%0d] got=%b exp=%b", k, bus.Hmaster, ep); end n_tests++;
         if (bus.Hmaster_d !== ep2) begin n_fail++; $display("FAIL t2_hmd[%0d] got=%b exp=%b", k, bus.Hmaster_d, ep2); end n_tests++;
         ep2 = ep;
         ep  = e;
      end
   endtask

   task automatic test_burst4();
      do_reset();
      bus.Hbusreq = 2'b10;
      bus.Htrans  = NONSEQ;
      bus.Hburst  = 3'd3;
      step();
      if (bus.Hgrant !== 2'b01) begin n_fail++; $display("FAIL t3_beat1 got=%b exp=01", bus.Hgrant); end n_tests++;
      bus.Htrans = SEQ;
      step();
      if (bus.Hgrant !== 2'b01) begin n_fail++; $display("FAIL t3_beat2 got=%b exp=01", bus.Hgrant); end n_tests++;
      step();
      if (bus.Hgrant !== 2'b10) begin n_fail++; $display("FAIL t3_beat3_grant got=%b exp=10", bus.Hgrant); end n_tests++;
      if (bus.Hmaster !== 1'b0) begin n_fail++; $display("FAIL t3_beat3_hm got=%b exp=0", bus.Hmaster); end n_tests++;
      step();
      if (bus.Hmaster !== 1'b1) begin n_fail++; $display("FAIL t3_beat4_hm got=%b exp=1", bus.Hmaster); end n_tests++;
      if (bus.Hgrant !== 2'b10) begin n_fail++; $display("FAIL t3_beat4_grant got=%b exp=10", bus.Hgrant); end n_tests++;
      bus.Htrans = IDLE;
   endtask

   task automatic test_burst8_busy();
      logic [1:0] tr [10];
      logic       rdy [10];
      logic [1:0] eg [10];
      tr  = '{NONSEQ, SEQ, BUSY, SEQ, BUSY, SEQ, SEQ, SEQ, SEQ, SEQ};
      rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      eg  = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
      do_reset();
      bus.Hbusreq = 2'b10;
      bus.Hburst  = 3'd5;
      for (int k = 0; k < 10; k++) begin
         bus.Htrans = tr[k];
         bus.Hready = rdy[k];
         step();
         if (bus.Hgrant !== eg[k]) begin n_fail++; $display("FAIL t4_incr8[%0d] got=%b exp=%b", k, bus.Hgrant, eg[k]); end n_tests++;
      end
      bus.Hready = 1'b1;
      do_reset();
      bus.Hbusreq = 2'b10;
      bus.Hburst  = 3'd5;
      bus.Htrans  = NONSEQ;
      step();
      bus.Htrans = SEQ;
      step();
      step();
      if (bus.Hgrant !== 2'b01) begin n_fail++; $display("FAIL t4_pre_idle got=%b exp=01", bus.Hgrant); end n_tests++;
      bus.Htrans = IDLE;
      step();
      if (bus.Hgrant !== 2'b10) begin n_fail++; $display("FAIL t4_idle_term got=%b exp=10", bus.Hgrant); end n_tests++;
   endtask

   task automatic test_lock();
      do_reset();
      bus.Hbusreq = 2'b10;
      bus.Hlock   = 2'b10;
      step();
      if (bus.Hgrant !== 2'b10) begin n_fail++; $display("FAIL t5_grant got=%b exp=10", bus.Hgrant); end n_tests++;
      if (bus.Hmastlock !== 1'b0) begin n_fail++; $display("FAIL t5_lock_early got=%b exp=0", bus.Hmastlock); end n_tests++;
      step();
      if (bus.Hmastlock !== 1'b1) begin n_fail++; $display("FAIL t5_lock_ph1 got=%b exp=1", bus.Hmastlock); end n_tests++;
      if (bus.Hmaster !== 1'b1) begin n_fail++; $display("FAIL t5_hm got=%b exp=1", bus.Hmaster); end n_tests++;
      bus.Hbusreq = 2'b01;
      bus.Htrans  = NONSEQ;
      bus.Hburst  = 3'd0;
      for (int k = 2; k <= 3; k++) begin
         step();
         if (bus.Hgrant !== 2'b10) begin n_fail++; $display("FAIL t5_hold[%0d] got=%b exp=10", k, bus.Hgrant); end n_tests++;
         if (bus.Hmastlock !== 1'b1) begin n_fail++; $display("FAIL t5_lock_ph%0d got=%b exp=1", k, bus.Hmastlock); end n_tests++;
      end
      bus.Hlock = 2'b00;
      step();
      if (bus.Hgrant !== 2'b01) begin n_fail++; $display("FAIL t5_release got=%b exp=01", bus.Hgrant); end n_tests++;
      if (bus.Hmastlock !== 1'b0) begin n_fail++; $display("FAIL t5_unlock got=%b exp=0", bus.Hmastlock); end n_tests++;
      bus.Htrans = IDLE;
   endtask

   task automatic test_async_reset();
      do_reset();
      bus.Hbusreq = 2'b10;
      bus.Hlock   = 2'b10;
      step();
      step();
      bus.Hbusreq = 2'b11;
      bus.Htrans  = NONSEQ;
      bus.Hburst  = 3'd7;
      step();
      bus.Htrans = SEQ;
      for (int k = 0; k < 4; k++) step();
      if (bus.Hgrant !== 2'b10) begin n_fail++; $display("FAIL t6_mid_grant got=%b exp=10", bus.Hgrant); end n_tests++;
      if (bus.Hmaster_d !== 1'b1) begin n_fail++; $display("FAIL t6_mid_hmd got=%b exp=1", bus.Hmaster_d); end n_tests++;
      if (bus.Hmastlock !== 1'b1) begin n_fail++; $display("FAIL t6_mid_lock got=%b exp=1", bus.Hmastlock); end n_tests++;
      #2;
      Hresetn = 1'b0;
      #1;
      if (bus.Hgrant !== 2'b01) begin n_fail++; $display("FAIL t6_arst_grant got=%b exp=01", bus.Hgrant); end n_tests++;
      if (bus.Hmaster !== 1'b0) begin n_fail++; $display("FAIL t6_arst_hm got=%b exp=0", bus.Hmaster); end n_tests++;
      if (bus.Hmaster_d !== 1'b0) begin n_fail++; $display("FAIL t6_arst_hmd got=%b exp=0", bus.Hmaster_d); end n_tests++;
      if (bus.Hmastlock !== 1'b0) begin n_fail++; $display("FAIL t6_arst_lock got=%b exp=0", bus.Hmastlock); end n_tests++;
      #2;
      Hresetn   = 1'b1;
      bus.Hlock = 2'b00;
      step();
      if (bus.Hgrant !== 2'b10) begin n_fail++; $display("FAIL t6_post_rst got=%b exp=10", bus.Hgrant); end n_tests++;
      bus.Htrans = IDLE;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_alternate();
      test_burst4();
      test_burst8_busy();
      test_lock();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
